// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA joystick scanner.
//   scan_state_t   : four-phase scan FSM encoding (player 1 settle/sample,
//                    player 2 settle/sample).
//   *_DEF          : default timing constants for the scanner parameters.
//   cnt_bits()     : width of a counter that must hold values 0..max_val.
package jamma_pkg;

    typedef enum logic [1:0] {
        P1_SETTLE = 2'd0,
        P1_SAMPLE = 2'd1,
        P2_SETTLE = 2'd2,
        P2_SAMPLE = 2'd3
    } scan_state_t;

    localparam int SETTLE_DEF     = 4;
    localparam int DB_COUNT_DEF   = 16;
    localparam int COIN_PULSE_DEF = 8;

    function automatic int cnt_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/jamma_debounce.sv
// Single-bit counting debouncer.
//   clk12 : clock
//   reset : synchronous active-high reset (stable level -> 1, counter -> 0)
//   en    : sample strobe; the input is only looked at when en is high
//   din   : raw sample
//   dout  : debounced stable level (registered)
// A run of DB_COUNT consecutive samples that differ from the stable level
// replaces it; any sample equal to the stable level restarts the run.
module jamma_debounce
    import jamma_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic clk12,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_bits(DB_COUNT);

    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic [CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CW'(1);

    // The counter is cleared on acceptance, so it never reaches DB_COUNT
    // as a stored value and can never wrap.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (en) begin
            if (din == r_stable) begin
                r_cnt <= '0;
            end else if (w_cnt_inc == CW'(DB_COUNT)) begin
                r_stable <= din;
                r_cnt    <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign dout = r_stable;

endmodule

// File: rtl/jamma_joy_scanner.sv
// JAMMA multiplexed joystick / coin scanner.
//   clk12     : sole clock (12 MHz)
//   reset     : synchronous active-high reset
//   jjoy      : multiplexed player inputs, active-low, bit7 = start
//   jcoin     : coin switches, active-low, asynchronous
//   local_joy : local joystick, active-low, asynchronous, merged into player 1
//   jselect   : mux select, 0 = player 1, 1 = player 2
//   joy1/joy2 : debounced player inputs, active-low
//   coin      : conditioned coin pulses, active-low, COIN_PULSE frames wide
//   frame     : one-cycle strobe on the player 2 sample cycle
module jamma_joy_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE     = SETTLE_DEF,
    parameter int DB_COUNT   = DB_COUNT_DEF,
    parameter int COIN_PULSE = COIN_PULSE_DEF
) (
    input  logic       clk12,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] local_joy,
    output logic       jselect,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] coin,
    output logic       frame
);

    localparam int SW = cnt_bits(SETTLE);
    localparam int PW = cnt_bits(COIN_PULSE);

    scan_state_t   r_state;
    logic [SW-1:0] r_settle;
    logic          r_jselect;
    logic          r_frame;
    logic          r_frame_d;
    logic          w_settle_done;
    logic          w_en_p1;
    logic          w_en_p2;

    logic [5:0]    r_ljoy_s1, r_ljoy_s2;
    logic [1:0]    r_jcoin_s1, r_jcoin_s2;

    logic [7:0]    w_stable1;
    logic [7:0]    w_stable2;
    logic [1:0]    w_coin_db;

    logic [7:0]    r_joy1;
    logic [7:0]    r_joy2;
    logic [1:0]    r_coin;
    logic [1:0]    r_armed;
    logic [PW-1:0] r_pcnt [2];

    assign w_settle_done = (r_settle == SW'(SETTLE - 1));
    assign w_en_p1       = (r_state == P1_SAMPLE);
    assign w_en_p2       = (r_state == P2_SAMPLE);

    // Scan FSM. jselect and frame are registered alongside the state so
    // they always describe the state currently held.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_state   <= P1_SETTLE;
            r_settle  <= '0;
            r_jselect <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            case (r_state)
                P1_SETTLE: begin
                    r_frame <= 1'b0;
                    if (w_settle_done) begin
                        r_settle <= '0;
                        r_state  <= P1_SAMPLE;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                P1_SAMPLE: begin
                    r_state   <= P2_SETTLE;
                    r_jselect <= 1'b1;
                end
                P2_SETTLE: begin
                    if (w_settle_done) begin
                        r_settle <= '0;
                        r_state  <= P2_SAMPLE;
                        r_frame  <= 1'b1;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                P2_SAMPLE: begin
                    r_state   <= P1_SETTLE;
                    r_jselect <= 1'b0;
                    r_frame   <= 1'b0;
                end
                default: begin
                    r_state   <= P1_SETTLE;
                    r_settle  <= '0;
                    r_jselect <= 1'b0;
                    r_frame   <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchronisers; reset to the released (high) level so that
    // leaving reset never looks like a press or a coin.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_ljoy_s1  <= '1;
            r_ljoy_s2  <= '1;
            r_jcoin_s1 <= '1;
            r_jcoin_s2 <= '1;
        end else begin
            r_ljoy_s1  <= local_joy;
            r_ljoy_s2  <= r_ljoy_s1;
            r_jcoin_s1 <= jcoin;
            r_jcoin_s2 <= r_jcoin_s1;
        end
    end

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_p1
        jamma_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk12 (clk12),
            .reset (reset),
            .en    (w_en_p1),
            .din   (jjoy[gi]),
            .dout  (w_stable1[gi])
        );
    end

    for (gi = 0; gi < 8; gi++) begin : g_p2
        jamma_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk12 (clk12),
            .reset (reset),
            .en    (w_en_p2),
            .din   (jjoy[gi]),
            .dout  (w_stable2[gi])
        );
    end

    for (gi = 0; gi < 2; gi++) begin : g_coin
        jamma_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk12 (clk12),
            .reset (reset),
            .en    (w_en_p2),
            .din   (r_jcoin_s2[gi]),
            .dout  (w_coin_db[gi])
        );
    end

    // Player outputs. Local joystick bits are only synchronised, so they
    // reach joy1 without any debounce delay.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_joy1 <= 8'hFF;
            r_joy2 <= 8'hFF;
        end else begin
            r_joy1 <= {w_stable1[7:6], w_stable1[5:0] & r_ljoy_s2};
            r_joy2 <= w_stable2;
        end
    end

    // Coin pulse stretcher. A pulse starts the cycle after the debounced
    // level goes low and is counted down on the delayed frame strobe, which
    // has the same phase as the start cycle, so the pulse spans exactly
    // COIN_PULSE full frames. A coin is re-armed only while its debounced
    // level is high, so a coin held low gives a single pulse.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_frame_d <= 1'b0;
            r_coin    <= 2'b11;
            r_armed   <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_pcnt[i] <= '0;
            end
        end else begin
            r_frame_d <= r_frame;
            for (int i = 0; i < 2; i++) begin
                if (r_pcnt[i] != '0) begin
                    if (r_frame_d) begin
                        if (r_pcnt[i] == PW'(1)) begin
                            r_coin[i] <= 1'b1;
                        end
                        r_pcnt[i] <= r_pcnt[i] - PW'(1);
                    end
                end else if (r_armed[i] && !w_coin_db[i]) begin
                    r_coin[i]  <= 1'b0;
                    r_pcnt[i]  <= PW'(COIN_PULSE);
                    r_armed[i] <= 1'b0;
                end
                if (w_coin_db[i]) begin
                    r_armed[i] <= 1'b1;
                end
            end
        end
    end

    assign jselect = r_jselect;
    assign frame   = r_frame;
    assign joy1    = r_joy1;
    assign joy2    = r_joy2;
    assign coin    = r_coin;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
module tb_jamma_joy_scanner;

    localparam int SETTLE     = 4;
    localparam int DB_COUNT   = 16;
    localparam int COIN_PULSE = 8;
    localparam int FRM        = 2 * (SETTLE + 1);
    localparam int PULSE_CYC  = COIN_PULSE * FRM;

    logic       clk12 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] jjoy = 8'hFF;
    logic [1:0] jcoin = 2'b11;
    logic [5:0] local_joy = 6'h3F;
    logic       jselect;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic [1:0] coin;
    logic       frame;

    int checks = 0;
    int errors = 0;

    jamma_joy_scanner #(
        .SETTLE     (SETTLE),
        .DB_COUNT   (DB_COUNT),
        .COIN_PULSE (COIN_PULSE)
    ) dut (
        .clk12     (clk12),
        .reset     (reset),
        .jjoy      (jjoy),
        .jcoin     (jcoin),
        .local_joy (local_joy),
        .jselect   (jselect),
        .joy1      (joy1),
        .joy2      (joy2),
        .coin      (coin),
        .frame     (frame)
    );

    always #41 clk12 = ~clk12;

    // ------------------------------------------------------------------
    // Reference model: cycle index since reset release decides the scan
    // phase; debounce follows the counting rule; coin pulses are modelled
    // as low windows [start, end] in cycle numbers.
    // ------------------------------------------------------------------
    int         k;
    logic [7:0] m_st1, m_st2;
    int         m_cnt1 [8];
    int         m_cnt2 [8];
    logic [1:0] m_stc;
    int         m_cntc [2];
    logic [5:0] lj_h1, lj_h2;
    logic [1:0] jc_h1, jc_h2;
    logic [1:0] m_armed;
    int         c_start [2];
    int         c_end [2];
    logic [7:0] e_joy1, e_joy2;
    logic [1:0] e_coin;
    logic       e_frame, e_jsel;

    task automatic model_reset();
        k = 0;
        m_st1 = 8'hFF; m_st2 = 8'hFF; m_stc = 2'b11;
        for (int i = 0; i < 8; i++) begin m_cnt1[i] = 0; m_cnt2[i] = 0; end
        for (int i = 0; i < 2; i++) begin m_cntc[i] = 0; c_start[i] = -10; c_end[i] = -20; end
        lj_h1 = 6'h3F; lj_h2 = 6'h3F; jc_h1 = 2'b11; jc_h2 = 2'b11;
        m_armed = 2'b11;
        e_joy1 = 8'hFF; e_joy2 = 8'hFF; e_coin = 2'b11; e_frame = 1'b0; e_jsel = 1'b0;
    endtask

    task automatic db_rule(input logic s, input logic st_in, input int c_in,
                           output logic st_out, output int c_out);
        st_out = st_in;
        c_out  = 0;
        if (s != st_in) begin
            c_out = c_in + 1;
            if (c_out == DB_COUNT) begin
                st_out = s;
                c_out  = 0;
            end
        end
    endtask

    // Advance one clock: capture this cycle's inputs, clock, update model,
    // and return on the following falling edge.
    task automatic step();
        logic [7:0] jj;
        logic [5:0] lj;
        logic [1:0] jc;
        logic       ts;
        int         tc;
        int         ph;
        jj = jjoy; lj = local_joy; jc = jcoin; ph = k % FRM;
        @(posedge clk12);
        e_joy1 = {m_st1[7:6], m_st1[5:0] & lj_h2};
        e_joy2 = m_st2;
        for (int i = 0; i < 2; i++) begin
            if (!m_stc[i] && m_armed[i] && k > c_end[i]) begin
                c_start[i] = k + 1;
                c_end[i]   = k + PULSE_CYC;
                m_armed[i] = 1'b0;
            end
            if (m_stc[i]) m_armed[i] = 1'b1;
        end
        if (ph == SETTLE) begin
            for (int i = 0; i < 8; i++) begin
                db_rule(jj[i], m_st1[i], m_cnt1[i], ts, tc);
                m_st1[i] = ts; m_cnt1[i] = tc;
            end
        end
        if (ph == FRM - 1) begin
            for (int i = 0; i < 8; i++) begin
                db_rule(jj[i], m_st2[i], m_cnt2[i], ts, tc);
                m_st2[i] = ts; m_cnt2[i] = tc;
            end
            for (int i = 0; i < 2; i++) begin
                db_rule(jc_h2[i], m_stc[i], m_cntc[i], ts, tc);
                m_stc[i] = ts; m_cntc[i] = tc;
            end
        end
        lj_h2 = lj_h1; lj_h1 = lj;
        jc_h2 = jc_h1; jc_h1 = jc;
        k++;
        e_jsel  = ((k % FRM) >= SETTLE + 1);
        e_frame = ((k % FRM) == FRM - 1);
        for (int i = 0; i < 2; i++) e_coin[i] = !(k >= c_start[i] && k <= c_end[i]);
        @(negedge clk12);
    endtask

    task automatic do_reset();
        @(negedge clk12);
        reset = 1'b1;
        jjoy = 8'hFF; jcoin = 2'b11; local_joy = 6'h3F;
        repeat (2) @(posedge clk12);
        @(negedge clk12);
        reset = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++; if (joy1 !== 8'hFF) begin errors++; $display("FAIL reset_joy1 got %h want ff", joy1); end
        checks++; if (joy2 !== 8'hFF) begin errors++; $display("FAIL reset_joy2 got %h want ff", joy2); end
        checks++; if (coin !== 2'b11) begin errors++; $display("FAIL reset_coin got %b want 11", coin); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", frame); end
        checks++; if (jselect !== 1'b0) begin errors++; $display("FAIL reset_jselect got %b want 0", jselect); end
    endtask

    task automatic test_scan_sequence();
        do_reset();
        for (int c = 1; c <= 4 * FRM; c++) begin
            step();
            checks++;
            if (jselect !== (((c % 10) >= 5) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL scan_jselect cycle %0d got %b want %b", c, jselect, e_jsel);
            end
            checks++;
            if (frame !== (((c % 10) == 9) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL scan_frame cycle %0d got %b want %b", c, frame, e_frame);
            end
        end
    endtask

    task automatic test_p1_debounce();
        do_reset();
        for (int c = 0; c < 17 * FRM; c++) begin
            jjoy = ((k % FRM) <= SETTLE) ? 8'hFE : 8'hFF;
            step();
            checks++;
            if (joy1 !== e_joy1 || joy2 !== e_joy2) begin
                errors++; $display("FAIL p1_db cycle %0d got %h/%h want %h/%h", k, joy1, joy2, e_joy1, e_joy2);
            end
            if (k == 15 * FRM + SETTLE + 1) begin
                checks++;
                if (joy1 !== 8'hFF) begin errors++; $display("FAIL p1_db_early got %h want ff", joy1); end
            end
        end
        checks++; if (joy1 !== 8'hFE) begin errors++; $display("FAIL p1_db_final_joy1 got %h want fe", joy1); end
        checks++; if (joy2 !== 8'hFF) begin errors++; $display("FAIL p1_db_final_joy2 got %h want ff", joy2); end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int c = 0; c < 40 * FRM; c++) begin
            jjoy = {7'h7F, ((k / FRM) % 2 == 0) ? 1'b0 : 1'b1};
            step();
            checks++;
            if (joy1[0] !== 1'b1 || joy1 !== e_joy1) begin
                errors++; $display("FAIL bounce cycle %0d got %h want %h", k, joy1, e_joy1);
            end
        end
    endtask

    task automatic test_local_joy();
        do_reset();
        repeat (3) step();
        local_joy = 6'b111101;
        step(); step();
        checks++; if (joy1 !== 8'hFF) begin errors++; $display("FAIL local_joy_early got %h want ff", joy1); end
        step();
        checks++; if (joy1 !== 8'hFD) begin errors++; $display("FAIL local_joy got %h want fd", joy1); end
        local_joy = 6'h3F;
        repeat (3) step();
        checks++; if (joy1 !== 8'hFF) begin errors++; $display("FAIL local_joy_release got %h want ff", joy1); end
    endtask

    task automatic test_coin_single();
        int low_cyc, pulses;
        logic prev;
        do_reset();
        jcoin = 2'b10;
        low_cyc = 0; pulses = 0; prev = 1'b1;
        for (int c = 0; c < 100 * FRM; c++) begin
            step();
            checks++;
            if (coin !== e_coin) begin errors++; $display("FAIL coin_model cycle %0d got %b want %b", k, coin, e_coin); end
            if (!coin[0]) low_cyc++;
            if (prev && !coin[0]) pulses++;
            prev = coin[0];
            if (coin[1] !== 1'b1) begin checks++; errors++; $display("FAIL coin1_idle cycle %0d got %b want 1", k, coin[1]); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL coin_pulse_count got %0d want 1", pulses); end
        checks++; if (low_cyc != 80) begin errors++; $display("FAIL coin_pulse_width got %0d want 80", low_cyc); end
    endtask

    task automatic test_coin_dual();
        int both_low, low0, low1;
        do_reset();
        jcoin = 2'b00;
        both_low = 0; low0 = 0; low1 = 0;
        for (int c = 0; c < 30 * FRM; c++) begin
            step();
            checks++;
            if (coin !== e_coin) begin errors++; $display("FAIL coin_dual_model cycle %0d got %b want %b", k, coin, e_coin); end
            if (coin == 2'b00) both_low++;
            if (!coin[0]) low0++;
            if (!coin[1]) low1++;
        end
        checks++; if (both_low != 80) begin errors++; $display("FAIL coin_dual_overlap got %0d want 80", both_low); end
        checks++; if (low0 != 80 || low1 != 80) begin errors++; $display("FAIL coin_dual_width got %0d/%0d want 80/80", low0, low1); end
    endtask

    task automatic test_reset_mid_pulse();
        int waited, lows;
        do_reset();
        jcoin = 2'b10;
        waited = 0;
        while (coin[0] !== 1'b0 && waited < 400) begin step(); waited++; end
        checks++;
        if (coin[0] !== 1'b0) begin errors++; $display("FAIL midreset_start got %b want 0 within 400 cycles", coin[0]); end
        repeat (3 * FRM) step();
        checks++; if (coin[0] !== 1'b0) begin errors++; $display("FAIL midreset_inpulse got %b want 0", coin[0]); end
        reset = 1'b1;
        jcoin = 2'b11;
        @(posedge clk12);
        @(negedge clk12);
        checks++; if (coin !== 2'b11) begin errors++; $display("FAIL midreset_coin got %b want 11", coin); end
        @(posedge clk12);
        @(negedge clk12);
        reset = 1'b0;
        model_reset();
        lows = 0;
        for (int c = 0; c < 40 * FRM; c++) begin
            step();
            if (coin !== 2'b11) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL midreset_after got %0d low cycles want 0", lows); end
    endtask

    task automatic test_random();
        logic [7:0] t1, t2;
        do_reset();
        t1 = 8'hFF; t2 = 8'hFF;
        for (int c = 0; c < 300 * FRM; c++) begin
            if ((k % FRM) == 0 && $urandom_range(0, 11) == 0) t1 = 8'($urandom);
            if ((k % FRM) == 0 && $urandom_range(0, 11) == 0) t2 = 8'($urandom);
            jjoy = ((k % FRM) <= SETTLE) ? t1 : t2;
            if ($urandom_range(0, 15) == 0) jjoy = jjoy ^ 8'($urandom);
            if ($urandom_range(0, 29) == 0) local_joy = 6'($urandom);
            if ($urandom_range(0, 399) == 0) jcoin[0] = ~jcoin[0];
            if ($urandom_range(0, 399) == 0) jcoin[1] = ~jcoin[1];
            step();
            checks++;
            if (joy1 !== e_joy1 || joy2 !== e_joy2 || coin !== e_coin ||
                jselect !== e_jsel || frame !== e_frame) begin
                errors++;
                $display("FAIL random cycle %0d got j1=%h j2=%h c=%b s=%b f=%b want j1=%h j2=%h c=%b s=%b f=%b",
                         k, joy1, joy2, coin, jselect, frame, e_joy1, e_joy2, e_coin, e_jsel, e_frame);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan_sequence();
        test_p1_debounce();
        test_bounce();
        test_local_joy();
        test_coin_single();
        test_coin_dual();
        test_reset_mid_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
